// File: rtl/temp_word_tx.sv
// Nibble-serial transmitter for one 8-bit temperature word plus unit code to a converter.
// Optional parity nibble (hi ^ lo) after the low nibble when TEMP_TX_PARITY_EN is defined.
module temp_word_tx #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       go,
  input  logic [7:0] temp,
  input  logic [1:0] unit,
  output logic [3:0] X,
  output logic [1:0] sel,
  output logic       ld,
  output logic       st,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE,
    HI,
    GAP_HI,
    LO,
    GAP_LO,
    START,
    FIN
`ifdef TEMP_TX_PARITY_EN
    ,
    PAR,
    GAP_PAR
`endif
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] temp_reg, temp_next;
  logic [3:0] x_reg, x_next;
  logic [1:0] sel_reg, sel_next;
  logic       ld_reg, ld_next;
  logic       st_reg, st_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      temp_reg  <= '0;
      x_reg     <= '0;
      sel_reg   <= '0;
      ld_reg    <= 1'b0;
      st_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      temp_reg  <= temp_next;
      x_reg     <= x_next;
      sel_reg   <= sel_next;
      ld_reg    <= ld_next;
      st_reg    <= st_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    temp_next  = temp_reg;
    sel_next   = sel_reg;
    x_next     = x_reg;

    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = HI;
          temp_next  = temp;
          // Kelvin has two codes on the input but only one on the converter side
          sel_next   = unit[1] ? 2'b10 : unit;
        end
      end
      HI: state_next = GAP_HI;
      GAP_HI: begin
        if (cnt_reg == GAP_LAST) state_next = LO;
        else                     cnt_next   = cnt_reg + 4'd1;
      end
      LO: state_next = GAP_LO;
      GAP_LO: begin
        if (cnt_reg == GAP_LAST) begin
`ifdef TEMP_TX_PARITY_EN
          state_next = PAR;
`else
          state_next = START;
`endif
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
`ifdef TEMP_TX_PARITY_EN
      PAR: state_next = GAP_PAR;
      GAP_PAR: begin
        if (cnt_reg == GAP_LAST) state_next = START;
        else                     cnt_next   = cnt_reg + 4'd1;
      end
`endif
      START:   state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it
    ld_next   = (state_next == HI) || (state_next == LO);
    st_next   = (state_next == START);
    done_next = (state_next == FIN);
    busy_next = (state_next != IDLE);

    case (state_next)
      HI: x_next = temp_next[7:4];
      LO: x_next = temp_reg[3:0];
`ifdef TEMP_TX_PARITY_EN
      PAR: begin
        x_next  = temp_reg[7:4] ^ temp_reg[3:0];
        ld_next = 1'b1;
      end
`endif
      default: x_next = x_reg;
    endcase
  end

  assign X    = x_reg;
  assign sel  = sel_reg;
  assign ld   = ld_reg;
  assign st   = st_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
